// File: rtl/tern_pkg.sv
// rtl/tern_pkg.sv - shared ternary op, FSM state and trit code definitions
package tern_pkg;

  typedef enum logic [1:0] {
    OP_MIN  = 2'b00,
    OP_MAX  = 2'b01,
    OP_CONS = 2'b10,
    OP_ANY  = 2'b11
  } tern_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } tern_state_e;

  // Codes are {t1,t0}
  localparam logic [1:0] TRIT_0   = 2'b00;
  localparam logic [1:0] TRIT_1   = 2'b10;
  localparam logic [1:0] TRIT_2   = 2'b01;
  localparam logic [1:0] TRIT_ILL = 2'b11;

endpackage

// File: rtl/ternary_trit_unit.sv
// rtl/ternary_trit_unit.sv - combinational two-wire ternary gate set with 4:1 op select
module ternary_trit_unit
  import tern_pkg::*;
(
  input  tern_op_e op,
  input  logic     a0,
  input  logic     a1,
  input  logic     b0,
  input  logic     b1,
  output logic     out0,
  output logic     out1
);

  logic min0, min1, max0, max1, cons0, cons1, any0, any1;
  logic az, bz;

  assign az = ~a0 & ~a1;
  assign bz = ~b0 & ~b1;

  // t0 marks value 2, t1 marks value 1; gates stay pure bitwise so code 11 is unchecked
  assign max0  = a0 | b0;
  assign max1  = (a1 | b1) & ~max0;
  assign min0  = a0 & b0;
  assign min1  = (a0 | a1) & (b0 | b1) & ~min0;
  assign cons0 = a0 & b0;
  assign cons1 = (a0 | a1 | b0 | b1) & ~cons0;
  // ANY behaves as saturating a+b-1
  assign any0  = (a1 & b0) | (a0 & b1) | (a0 & b0);
  assign any1  = (a1 & b1) | (a0 & bz) | (az & b0);

  always_comb begin
    out0 = 1'b0;
    out1 = 1'b0;
    case (op)
      OP_MIN:  begin out0 = min0;  out1 = min1;  end
      OP_MAX:  begin out0 = max0;  out1 = max1;  end
      OP_CONS: begin out0 = cons0; out1 = cons1; end
      default: begin out0 = any0;  out1 = any1;  end
    endcase
  end

endmodule

// File: rtl/ternary_word_sequencer.sv
// rtl/ternary_word_sequencer.sv - trit-serial word op sequencer; TERN_ILLEGAL_CHECK_EN adds err
module ternary_word_sequencer
  import tern_pkg::*;
#(
  parameter int N_TRITS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic [N_TRITS-1:0] in_a0,
  input  logic [N_TRITS-1:0] in_a1,
  input  logic [N_TRITS-1:0] in_b0,
  input  logic [N_TRITS-1:0] in_b1,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_TRITS-1:0] out0,
  output logic [N_TRITS-1:0] out1,
`ifdef TERN_ILLEGAL_CHECK_EN
  output logic               err,
`endif
  output logic               busy
);

  localparam int CNT_W = (N_TRITS > 1) ? $clog2(N_TRITS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_TRITS - 1);

  tern_state_e        state;
  tern_op_e           op_q;
  logic [CNT_W-1:0]   idx;
  logic [N_TRITS-1:0] a0_q, a1_q, b0_q, b1_q;
  logic [N_TRITS-1:0] res0, res1;
  logic               u0, u1, t0, t1;

  ternary_trit_unit u_trit (
    .op   (op_q),
    .a0   (a0_q[idx]),
    .a1   (a1_q[idx]),
    .b0   (b0_q[idx]),
    .b1   (b1_q[idx]),
    .out0 (u0),
    .out1 (u1)
  );

`ifdef TERN_ILLEGAL_CHECK_EN
  logic ill;
  assign ill = (a0_q[idx] & a1_q[idx]) | (b0_q[idx] & b1_q[idx]);
  assign t0  = u0 & ~ill;
  assign t1  = u1 & ~ill;
`else
  assign t0 = u0;
  assign t1 = u1;
`endif

  assign out0 = res0;
  assign out1 = res1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= OP_MIN;
      idx       <= '0;
      a0_q      <= '0;
      a1_q      <= '0;
      b0_q      <= '0;
      b1_q      <= '0;
      res0      <= '0;
      res1      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef TERN_ILLEGAL_CHECK_EN
      err       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_q     <= tern_op_e'(in_op);
            a0_q     <= in_a0;
            a1_q     <= in_a1;
            b0_q     <= in_b0;
            b1_q     <= in_b1;
            res0     <= '0;
            res1     <= '0;
            idx      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_RUN;
`ifdef TERN_ILLEGAL_CHECK_EN
            err      <= 1'b0;
`endif
          end
        end
        ST_RUN: begin
          res0[idx] <= t0;
          res1[idx] <= t1;
`ifdef TERN_ILLEGAL_CHECK_EN
          if (ill) err <= 1'b1;
`endif
          if (idx == LAST_IDX) begin
            idx       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ternary_word_sequencer.sv
// tb/tb_ternary_word_sequencer.sv - directed vector bench for ternary_word_sequencer
module tb_ternary_word_sequencer;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   in_op = 2'b00;
  logic [N-1:0] in_a0 = '0, in_a1 = '0, in_b0 = '0, in_b1 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out0, out1;
  logic         busy;
`ifdef TERN_ILLEGAL_CHECK_EN
  logic         err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ternary_word_sequencer #(.N_TRITS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a0     (in_a0),
    .in_a1     (in_a1),
    .in_b0     (in_b0),
    .in_b1     (in_b1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out0      (out0),
    .out1      (out1),
`ifdef TERN_ILLEGAL_CHECK_EN
    .err       (err),
`endif
    .busy      (busy)
  );

  typedef struct {
    logic [1:0]   op;
    logic [N-1:0] exp0;
    logic [N-1:0] exp1;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Presents a request at a negedge while idle, scrambles inputs after the accept edge,
  // and counts posedges (accept edge included) until out_valid.
  task automatic do_req(input logic [1:0] op, input logic [N-1:0] a0, input logic [N-1:0] a1,
                        input logic [N-1:0] b0, input logic [N-1:0] b1, output int lat);
    @(negedge clk);
    in_op = op; in_a0 = a0; in_a1 = a1; in_b0 = b0; in_b1 = b1;
    in_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == 1) begin
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("in_ready_after_accept", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        in_op = ~op; in_a0 = ~a0; in_a1 = ~a1; in_b0 = ~b0; in_b1 = ~b1;
      end
    end while (!out_valid && lat < 50);
    if (lat >= 50) chk("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  localparam logic [N-1:0] A0 = 4'b1001, A1 = 4'b0100, B0 = 4'b0010, B1 = 4'b1100;

  initial begin
    int lat;
    logic [N-1:0] h0, h1;

    vecs[0] = '{2'b01, 4'b1011, 4'b0100};
    vecs[1] = '{2'b00, 4'b0000, 4'b1100};
    vecs[2] = '{2'b10, 4'b0000, 4'b1111};
    vecs[3] = '{2'b11, 4'b1000, 4'b0111};

    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out", {out1, out0}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_req(vecs[i].op, A0, A1, B0, B1, lat);
      chk($sformatf("latency_op%0d", i), lat, 32'd5);
      chk($sformatf("out0_op%0d", i), 32'(out0), 32'(vecs[i].exp0));
      chk($sformatf("out1_op%0d", i), 32'(out1), 32'(vecs[i].exp1));
      @(posedge clk); #1;
      chk($sformatf("drained_op%0d", i), 32'(out_valid), 32'd0);
      chk($sformatf("idle_ready_op%0d", i), 32'(in_ready), 32'd1);
    end

    // Backpressure: result held while a second request waits
    out_ready = 1'b0;
    do_req(2'b01, A0, A1, B0, B1, lat);
    h0 = out0; h1 = out1;
    chk("bp_first_out0", 32'(h0), 32'b1011);
    @(negedge clk);
    in_op = 2'b00; in_a0 = A0; in_a1 = A1; in_b0 = B0; in_b1 = B1;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_stable", {out1, out0}, {h1, h0});
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_not_accepted", 32'(busy), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_drain_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_second_accepted", 32'(busy), 32'd1);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    chk("bp_second_lat", lat, 32'd4);
    chk("bp_second_out", {out1, out0}, {4'b1100, 4'b0000});
    @(posedge clk); #1;

    // Reset during RUN cycle 2
    @(negedge clk);
    in_op = 2'b01; in_a0 = A0; in_a1 = A1; in_b0 = B0; in_b1 = B1;
    in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out", {out1, out0}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    lat = 0;
    while (out_valid === 1'b0 && lat < 8) begin @(posedge clk); #1; lat++; end
    chk("mid_rst_no_stale", 32'(out_valid), 32'd0);
    do_req(2'b11, A0, A1, B0, B1, lat);
    chk("fresh_lat", lat, 32'd5);
    chk("fresh_out", {out1, out0}, {4'b0111, 4'b1000});
    @(posedge clk); #1;

`ifdef TERN_ILLEGAL_CHECK_EN
    do_req(2'b01, A0, A1 | 4'b0001, B0, B1, lat);
    chk("ill_out", {out1, out0}, {4'b0100, 4'b1010});
    chk("ill_err", 32'(err), 32'd1);
    @(posedge clk); #1;
    chk("ill_err_sticky_idle", 32'(err), 32'd1);
    do_req(2'b01, A0, A1, B0, B1, lat);
    chk("ill_err_cleared", 32'(err), 32'd0);
    chk("ill_next_out", {out1, out0}, {4'b0100, 4'b1011});
    @(posedge clk); #1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
